// File: rtl/adder_issue_stage_if.sv
// Handshake and adder bundle for adder_issue_stage.
// slave = issue stage side, master = upstream/downstream/adder side.
interface adder_issue_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_c0;
    logic [WIDTH:0]   add_s;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_overflow;

    modport slave (
        input  in_valid, in_a, in_b, in_sub, add_s, out_ready,
        output in_ready, add_a, add_b, add_c0,
        output out_valid, out_sum, out_carry, out_overflow
    );

    modport master (
        output in_valid, in_a, in_b, in_sub, add_s, out_ready,
        input  in_ready, add_a, add_b, add_c0,
        input  out_valid, out_sum, out_carry, out_overflow
    );
endinterface

// File: rtl/adder_issue_stage.sv
// Issue stage: 2-entry request FIFO feeding an external adder, registered result.
// Define ADDER_ISSUE_OVF_EN to build the signed-overflow flag register.
module adder_issue_stage #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    adder_issue_stage_if.slave bus
);
    logic [WIDTH-1:0] r_a [2];
    logic [WIDTH-1:0] r_b [2];
    logic [1:0]       r_sub;
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_carry;

    logic             w_empty;
    logic             w_issue;
    logic             w_in_ready;
    logic             w_push;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_c0;

    assign w_empty    = (r_count == 2'd0);
    assign w_issue    = !w_empty && (!r_out_valid || bus.out_ready);
    assign w_in_ready = (r_count < 2'd2) || ((r_count == 2'd2) && w_issue);
    assign w_push     = bus.in_valid && w_in_ready;

    // Present the FIFO head to the adder; subtraction is A + ~B + 1.
    always_comb begin
        w_add_a  = '0;
        w_add_b  = '0;
        w_add_c0 = 1'b0;
        if (!w_empty) begin
            w_add_a  = r_a[r_rptr];
            w_add_b  = r_sub[r_rptr] ? ~r_b[r_rptr] : r_b[r_rptr];
            w_add_c0 = r_sub[r_rptr];
        end
    end

    // Request storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_a[r_wptr]   <= bus.in_a;
            r_b[r_wptr]   <= bus.in_b;
            r_sub[r_wptr] <= bus.in_sub;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_issue) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Result register: load on issue, drop after downstream accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_carry <= 1'b0;
        end else if (w_issue) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= bus.add_s[WIDTH-1:0];
            r_out_carry <= bus.add_s[WIDTH];
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef ADDER_ISSUE_OVF_EN
    logic r_out_ovf;
    logic w_ovf;

    assign w_ovf = (w_add_a[WIDTH-1] == w_add_b[WIDTH-1]) &&
                   (bus.add_s[WIDTH-1] != w_add_a[WIDTH-1]);

    // Signed overflow flag, captured alongside the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_ovf <= 1'b0;
        end else if (w_issue) begin
            r_out_ovf <= w_ovf;
        end
    end

    assign bus.out_overflow = r_out_ovf;
`else
    assign bus.out_overflow = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.add_a     = w_add_a;
    assign bus.add_b     = w_add_b;
    assign bus.add_c0    = w_add_c0;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_carry = r_out_carry;
endmodule

// File: tb/tb_adder_issue_stage.sv
// Self-checking bench for adder_issue_stage with a behavioural adder
// and a transaction-level result model.
module tb_adder_issue_stage;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } res_t;

    adder_issue_stage_if #(.WIDTH(W)) bus();

    adder_issue_stage #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.add_s = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_c0};

    always #5 clk = ~clk;

    res_t got;
    assign got = {bus.out_sum, bus.out_carry, bus.out_overflow};

    function automatic res_t ref_res(input logic [31:0] a, input logic [31:0] b,
                                     input logic sub);
        res_t   r;
        longint sa;
        longint sb;
        longint sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            r.sum   = a - b;
            r.carry = (a >= b);
            sr      = sa - sb;
        end else begin
            r.sum   = a + b;
            r.carry = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
            sr      = sa + sb;
        end
`ifdef ADDER_ISSUE_OVF_EN
        r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`else
        r.ovf = 1'b0;
`endif
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic sub);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
    endtask

    task automatic test_reset;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_out got=%h exp=0", got);
        end
        checks++;
        if ({bus.add_a, bus.add_b, bus.add_c0} !== '0) begin
            errors++;
            $display("FAIL reset_adder got=%h/%h/%b exp=0", bus.add_a, bus.add_b, bus.add_c0);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_add;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h5, 32'h3, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_early_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if ({bus.add_a, bus.add_b, bus.add_c0} !== {32'h5, 32'h3, 1'b0}) begin
            errors++;
            $display("FAIL add_operands got=%h/%h/%b exp=5/3/0", bus.add_a, bus.add_b, bus.add_c0);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 32'h8 || bus.out_carry !== 1'b0) begin
            errors++;
            $display("FAIL add_result got=%b/%h/%b exp=1/00000008/0",
                     bus.out_valid, bus.out_sum, bus.out_carry);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_drop_valid got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_sub;
        logic [31:0] ta [2] = '{32'd3, 32'd5};
        logic [31:0] tb [2] = '{32'd5, 32'd3};
        logic [31:0] ts [2] = '{32'hFFFF_FFFE, 32'd2};
        logic        tc [2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            drive(1'b1, ta[i], tb[i], 1'b1);
            @(negedge clk);
            drive(1'b0, 32'd0, 32'd0, 1'b0);
            checks++;
            if (bus.add_b !== ~tb[i] || bus.add_c0 !== 1'b1) begin
                errors++;
                $display("FAIL sub_operands[%0d] got=%h/%b exp=%h/1", i, bus.add_b, bus.add_c0, ~tb[i]);
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== ts[i] || bus.out_carry !== tc[i]) begin
                errors++;
                $display("FAIL sub_result[%0d] got=%b/%h/%b exp=1/%h/%b",
                         i, bus.out_valid, bus.out_sum, bus.out_carry, ts[i], tc[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        logic exp_ovf;
`ifdef ADDER_ISSUE_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h8000_0000, 32'h1, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        checks++;
        if (bus.out_sum !== 32'h8000_0000 || bus.out_overflow !== exp_ovf) begin
            errors++;
            $display("FAIL ovf_add got=%h/%b exp=80000000/%b", bus.out_sum, bus.out_overflow, exp_ovf);
        end
        @(negedge clk);
        checks++;
        if (got !== ref_res(32'h8000_0000, 32'h1, 1'b1)) begin
            errors++;
            $display("FAIL ovf_sub got=%h exp=%h", got, ref_res(32'h8000_0000, 32'h1, 1'b1));
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        res_t e [3];
        e[0] = ref_res(32'd10, 32'd20, 1'b0);
        e[1] = ref_res(32'd100, 32'd1, 1'b1);
        e[2] = ref_res(32'hFFFF_FFFF, 32'd1, 1'b0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 32'd10, 32'd20, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'd100, 32'd1, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || got !== e[0] || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got=%b/%h/%b exp=1/%h/0", bus.out_valid, got, bus.in_ready, e[0]);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || got !== e[0]) begin
            errors++;
            $display("FAIL bp_hold got=%b/%h exp=1/%h", bus.out_valid, got, e[0]);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_on_pop got=%b exp=1", bus.in_ready);
        end
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || got !== e[i]) begin
                errors++;
                $display("FAIL bp_order[%0d] got=%b/%h exp=1/%h", i, bus.out_valid, got, e[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic        vs [8];
        for (int i = 0; i < 8; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
            vs[i] = 1'($urandom_range(1));
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 8) drive(1'b1, va[k], vb[k], vs[k]);
            else       drive(1'b0, 32'd0, 32'd0, 1'b0);
            #1;
            checks++;
            if (bus.out_valid !== (k >= 2) || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_flow[%0d] got=%b/%b exp=%b/1", k, bus.out_valid, bus.in_ready, k >= 2);
            end
            if (k >= 2) begin
                checks++;
                if (got !== ref_res(va[k-2], vb[k-2], vs[k-2])) begin
                    errors++;
                    $display("FAIL b2b_result[%0d] got=%h exp=%h", k - 2, got,
                             ref_res(va[k-2], vb[k-2], vs[k-2]));
                end
            end
        end
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd1, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'd2, 32'd2, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'd3, 32'd3, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pre got=%b/%b exp=1/0", bus.out_valid, bus.in_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || got !== '0) begin
            errors++;
            $display("FAIL rstmid_async got=%b/%b/%h exp=0/1/0", bus.out_valid, bus.in_ready, got);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after got=%b/%b exp=1/0", bus.in_ready, bus.out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stale[%0d] got=%b exp=0", i, bus.out_valid);
            end
        end
        drive(1'b1, 32'h1234, 32'h10, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || got !== ref_res(32'h1234, 32'h10, 1'b1)) begin
            errors++;
            $display("FAIL rstmid_fresh got=%b/%h exp=1/%h", bus.out_valid, got,
                     ref_res(32'h1234, 32'h10, 1'b1));
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        res_t        fq[$];
        res_t        hr;
        logic        held;
        logic        iss;
        logic        rdy;
        logic        drain;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] corner [4] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        held = 1'b0;
        hr   = '0;
        for (int i = 0; i < 420; i++) begin
            drain = (i >= 400);
            @(negedge clk);
            a = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
            b = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
            s = 1'($urandom_range(1));
            drive(!drain && ($urandom_range(3) != 0), a, b, s);
            bus.out_ready = drain || ($urandom_range(2) != 0);
            #1;
            iss = (fq.size() > 0) && (!held || bus.out_ready);
            rdy = (fq.size() < 2) || ((fq.size() == 2) && iss);
            checks++;
            if (bus.out_valid !== held) begin
                errors++;
                $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, bus.out_valid, held);
            end
            if (held) begin
                checks++;
                if (got !== hr) begin
                    errors++;
                    $display("FAIL rnd_result[%0d] got=%h exp=%h", i, got, hr);
                end
            end
            checks++;
            if (bus.in_ready !== rdy) begin
                errors++;
                $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, bus.in_ready, rdy);
            end
            if (held && bus.out_ready) held = 1'b0;
            if (iss) begin
                hr   = fq.pop_front();
                held = 1'b1;
            end
            if (bus.in_valid && rdy) fq.push_back(ref_res(a, b, s));
        end
        checks++;
        if (held || fq.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain got=%0d left exp=0", fq.size() + int'(held));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_issue_stage.md
ADDER_ISSUE_STAGE -- requirements
Module: adder_issue_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; must equal the `INPUTSIZE of the attached adder.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream request valid.
REQ-005 SHALL have port in_ready  output  1  request FIFO can accept.
REQ-006 SHALL have port in_a  input  WIDTH  operand A.
REQ-007 SHALL have port in_b  input  WIDTH  operand B.
REQ-008 SHALL have port in_sub  input  1  1 = A-B, 0 = A+B.
REQ-009 SHALL have port add_a  output  WIDTH  to adder A.
REQ-010 SHALL have port add_b  output  WIDTH  to adder B.
REQ-011 SHALL have port add_c0  output  1  to adder carry-in.
REQ-012 SHALL have port add_s  input  WIDTH+1  adder result; bit WIDTH is carry-out.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts.
REQ-015 SHALL have port out_sum  output  WIDTH  registered add_s[WIDTH-1:0].
REQ-016 SHALL have port out_carry  output  1  registered add_s[WIDTH].
REQ-017 SHALL have port out_overflow  output  1  signed overflow flag.

Function
REQ-018 SHALL hold requests in a 2-entry FIFO (a, b, sub) with wrap-around read/write pointers and a 2-bit count.
REQ-019 SHALL assert in_ready when count < 2, or when count == 2 and the head issues this cycle.
REQ-020 SHALL push on in_valid && in_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-021 SHALL drive add_a = head.a, add_b = head.sub ? ~head.b : head.b, add_c0 = head.sub, combinationally from the FIFO head; all zeros when empty.
REQ-022 SHALL issue (pop head) when count > 0 and (!out_valid || out_ready).
REQ-023 SHALL, on issue, load out_sum, out_carry, out_overflow from add_s and set out_valid at the same edge; latency push-to-out_valid = 1 cycle.
REQ-024 SHALL clear out_valid when out_valid && out_ready and no issue occurs that cycle.
REQ-025 SHALL hold out_* stable while out_valid && !out_ready.
REQ-026 SHALL compute overflow = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_s[WIDTH-1] != add_a[WIDTH-1]).
REQ-027 SHALL sustain one result per cycle when out_ready stays high.
REQ-028 SHALL never accept a push when count == 2 and no pop occurs; no request is dropped or duplicated.

Reset
REQ-029 SHALL, on rst high, asynchronously clear FIFO pointers and count, out_valid, out_sum, out_carry, out_overflow to 0.
REQ-030 SHALL discard in-flight FIFO entries and the held result on reset mid-operation; in_ready SHALL be 1 the first cycle after rst deasserts.

Configuration
REQ-031 SHALL implement the overflow logic only when macro ADDER_ISSUE_OVF_EN is defined.
REQ-032 SHALL tie out_overflow to 0 and omit its register when ADDER_ISSUE_OVF_EN is undefined; all other behaviour unchanged.

Verification
REQ-033 SHALL cover add: a=0x00000005, b=0x00000003, sub=0, out_ready=1 -> next cycle out_valid=1, out_sum=0x00000008, out_carry=0.
REQ-034 SHALL cover sub: a=3, b=5, sub=1 -> out_sum=0xFFFFFFFE, out_carry=0; a=5, b=3, sub=1 -> out_sum=2, out_carry=1.
REQ-035 SHALL cover overflow (macro on): a=0x7FFFFFFF, b=1, sub=0 -> out_sum=0x80000000, out_overflow=1; macro off -> out_overflow=0.
REQ-036 SHALL cover backpressure: out_ready=0, push 3 requests -> first in out regs, 2 in FIFO, in_ready=0; raise out_ready -> results in order, one per cycle.
REQ-037 SHALL cover reset mid-operation: FIFO full, out_valid=1, pulse rst between edges -> out_valid=0, in_ready=1 immediately, no stale result later.
